seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Scan sequencer for the 4-digit multiplexed seven-segment display.
//   - Drives the active-low anodes and presents one nibble per digit slot to the
//     downstream hex-to-segment decoder.
//   - Inserts a dead-time blank between digits to suppress ghosting.
//   - Accepts new 16-bit display values over a valid/ready port.
//   - Values are double-buffered: they take effect only at a frame boundary,
//     so a displayed value never tears.
// PARAMETERS
//   REFRESH_DIV  100000  cycles each digit is lit per visit (>=2)
//   BLANK_CYC    16      cycles all anodes are off between digits (>=1)
// PORTS
//   clk          in   1   system clock; single clock domain
//   reset_n      in   1   asynchronous, active-low reset
//   enable       in   1   1 = scan display, 0 = display dark
//   load_valid   in   1   load_data is offered this cycle
//   load_ready   out  1   shadow register free; load accepted when valid&&ready
//   load_data    in   16  digit3..digit0 nibbles, [3:0] = digit 0 (rightmost)
//   blank_mask   in   4   1 = keep digit dark (e.g. leading-zero blanking)
//   dp_mask      in   4   1 = light the decimal point on that digit
//   an           out  4   anode enables, active-low, one-hot-low when lit
//   digit_hex    out  4   nibble for the currently lit digit
//   dp           out  1   decimal point, active-low
//   frame_done   out  1   one-cycle pulse at each frame boundary
// BEHAVIOUR
//   Reset (async assert; release synchronised to clk):
//     state=OFF, digit=0, counter=0, active=0, shadow=0, pending=0.
//     Output values in reset: an=4'b1111, digit_hex=0, dp=1, frame_done=0,
//     load_ready=1.
//   FSM states: OFF, SCAN, BLANK. an, digit_hex and dp are registered and
//     update in the same cycle as the state register.
//   OFF -> SCAN:
//     - Taken on the first clk edge with enable=1.
//     - Enters with digit=0 and counter=0.
//   SCAN:
//     - an = ~(1<<digit) unless blank_mask[digit]=1, in which case an=4'b1111.
//       blank_mask and dp_mask are sampled every cycle.
//     - digit_hex = active[4*digit+:4].
//     - dp = ~dp_mask[digit]; dp=1 when the digit is blanked.
//     - After REFRESH_DIV cycles in SCAN -> BLANK, counter=0.
//   BLANK:
//     - an=4'b1111 and dp=1; digit_hex holds its last value.
//     - After BLANK_CYC cycles -> SCAN with digit=digit+1 (2-bit wrap, 3->0).
//   Frame boundary (BLANK->SCAN transition with digit 3 wrapping to 0):
//     - frame_done=1 for exactly that cycle.
//     - If pending=1: active<=shadow and pending<=0 on that edge, so the new
//       value is shown starting with digit 0.
//   Frame period = 4*(REFRESH_DIV+BLANK_CYC) cycles.
//   Load handshake:
//     - load_ready = ~pending (combinational from a register).
//     - On valid&&ready: shadow<=load_data, pending<=1.
//     - load_ready is 0 on the commit edge and returns to 1 on the next cycle,
//       so a load and a commit never coincide.
//     - load_valid while load_ready=0 is ignored; the producer holds data.
//   enable=0 in any state:
//     - Next edge -> OFF; an=4'b1111, dp=1, digit=0, counter=0.
//     - A pending shadow commits on that edge and every OFF cycle.
//     - frame_done is not pulsed.
//   enable 0->1: restart at SCAN digit 0 with a full REFRESH_DIV slot.
//   Counter width: $clog2(max(REFRESH_DIV,BLANK_CYC)); no overflow possible.
//   reset_n low mid-frame or mid-handshake: every register returns to its reset
//     value immediately; a pending load is discarded.
// TESTING (REFRESH_DIV=4, BLANK_CYC=2, enable=1 unless stated)
//   1. Reset, load 16'h1234, observe 3 frames:
//      -> an sequence 1110(4 cyc), 1111(2 cyc), 1101, 1111, 1011, 1111, 0111, 1111.
//      -> digit_hex = 4,3,2,1 in the lit slots; frame_done every 24 cycles.
//   2. Load 16'hABCD mid-frame:
//      -> load_ready=0 until the boundary.
//      -> digit_hex shows the old value until the boundary, then D,C,B,A.
//      -> load_ready=1 on the cycle after frame_done.
//   3. Hold load_valid=1 with 16'h5555 while pending, then change to 16'h6666
//      once ready:
//      -> only accepted beats are displayed; no beat is lost or duplicated.
//   4. blank_mask=4'b1000, dp_mask=4'b0010:
//      -> an stays 1111 in the digit-3 slot.
//      -> dp=0 only during the digit-1 lit slot.
//   5. Drop enable during a digit-2 SCAN slot with a pending load:
//      -> an=1111 on the next edge and pending commits.
//      -> Re-enable: an=1110 with the new value, held 4 cycles.
//   6. Assert reset_n=0 mid-BLANK with a pending load:
//      -> outputs take their reset values asynchronously and the load is gone.
//      -> After release, an stays 1111 until enable is sampled.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Load port of the seven-segment scan controller: a 16-bit display value
// offered over a valid/ready handshake.
interface seg_scan_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed seven-segment display with dead-time
// blanking and a double-buffered display value committed at frame boundaries.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    seg_scan_ctrl_if.slave        load,
    input  logic [3:0]            blank_mask,
    input  logic [3:0]            dp_mask,
    output logic [3:0]            an,
    output logic [3:0]            digit_hex,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int unsigned CntMax = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] ScanLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {StOff, StScan, StBlank} state_e;

    state_e          st_q, st_d;
    logic [1:0]      digit_q, digit_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     active_q, active_d;
    logic [15:0]     shadow_q, shadow_d;
    logic            pending_q, pending_d;
    logic [3:0]      an_q, an_d;
    logic [3:0]      hex_q, hex_d;
    logic            dp_q, dp_d;
    logic            frame_done_q, frame_done_d;
    logic            load_fire;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    assign load.load_ready = ~pending_q;
    assign load_fire       = load.load_valid & ~pending_q;

    always_comb begin
        st_d         = st_q;
        digit_d      = digit_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;

        // Accept needs pending_q=0 while commit needs pending_q=1, so they never collide.
        if (load_fire) begin
            shadow_d  = load.load_data;
            pending_d = 1'b1;
        end

        if (!enable) begin
            st_d    = StOff;
            digit_d = 2'd0;
            cnt_d   = '0;
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else begin
            case (st_q)
                StOff: begin
                    st_d    = StScan;
                    digit_d = 2'd0;
                    cnt_d   = '0;
                end
                StScan: begin
                    if (cnt_q == ScanLast) begin
                        st_d  = StBlank;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        st_d    = StScan;
                        cnt_d   = '0;
                        digit_d = digit_q + 2'd1;
                        if (digit_q == 2'd3) begin
                            frame_done_d = 1'b1;
                            if (pending_q) begin
                                active_d  = shadow_q;
                                pending_d = 1'b0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    st_d    = StOff;
                    digit_d = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Display outputs are registered from the next state so they track the FSM exactly.
    always_comb begin
        an_d  = 4'b1111;
        dp_d  = 1'b1;
        hex_d = hex_q;
        if (st_d == StScan) begin
            hex_d = active_d[{digit_d, 2'b00} +: 4];
            if (!blank_mask[digit_d]) begin
                an_d = ~(4'b0001 << digit_d);
                dp_d = ~dp_mask[digit_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            st_q         <= StOff;
            digit_q      <= 2'd0;
            cnt_q        <= '0;
            active_q     <= 16'h0000;
            shadow_q     <= 16'h0000;
            pending_q    <= 1'b0;
            an_q         <= 4'b1111;
            hex_q        <= 4'h0;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            st_q         <= st_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            hex_q        <= hex_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign digit_hex  = hex_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected display runs are queued by the
// stimulus and compared by a monitor that segments the outputs into runs.
module tb_seg_scan_ctrl;

    localparam int unsigned RD = 4;
    localparam int unsigned BC = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] blank_mask = 4'b0000;
    logic [3:0] dp_mask = 4'b0000;
    logic [3:0] an;
    logic [3:0] digit_hex;
    logic       dp;
    logic       frame_done;

    seg_scan_ctrl_if lif ();

    seg_scan_ctrl #(
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (lif),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .an         (an),
        .digit_hex  (digit_hex),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int run_idx = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // len==0 means the run length is not checked; hex is only checked on lit runs.
    typedef struct {
        logic [3:0] an;
        logic       dp;
        logic [3:0] hex;
        int         len;
        int         fd;
    } run_t;

    run_t exp_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endfunction

    function automatic void push_run(logic [3:0] a, logic p, logic [3:0] h, int len, int fd);
        run_t e;
        run_t n;
        n.an = a; n.dp = p; n.hex = h; n.len = len; n.fd = fd;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_back();
            if (e.an == a && e.dp == p) begin
                e.len = (e.len == 0 || len == 0) ? 0 : e.len + len;
                e.fd  = e.fd + fd;
                exp_q.push_back(e);
            end else begin
                exp_q.push_back(e);
                exp_q.push_back(n);
            end
        end else begin
            exp_q.push_back(n);
        end
    endfunction

    function automatic void push_frame(logic [15:0] v, logic [3:0] bm, logic [3:0] dm, int fd0);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] a;
            logic       p;
            a = bm[d] ? 4'b1111 : ~(4'b0001 << d);
            p = bm[d] ? 1'b1 : ~dm[d];
            push_run(a, p, v[4*d +: 4], RD, (d == 0) ? fd0 : 0);
            push_run(4'b1111, 1'b1, 4'h0, BC, 0);
        end
    endfunction

    // Monitor: a run is a maximal stretch of constant {an, dp}.
    logic [3:0] cur_an;
    logic [3:0] cur_hex;
    logic       cur_dp;
    int         cur_len = 0;
    int         cur_fd = 0;
    bit         started = 1'b0;

    function automatic void emit_run();
        run_t e;
        bit   ok;
        checks++;
        run_idx++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL run%0d: got an=%b dp=%b len=%0d, expected no further run",
                     run_idx, cur_an, cur_dp, cur_len);
        end else begin
            e  = exp_q.pop_front();
            ok = (cur_an === e.an) && (cur_dp === e.dp) && (cur_fd == e.fd)
                 && (e.len == 0 || cur_len == e.len)
                 && (e.an == 4'b1111 || cur_hex === e.hex);
            if (!ok) begin
                errors++;
                $display("FAIL run%0d: got an=%b dp=%b hex=%h len=%0d fd=%0d, expected an=%b dp=%b hex=%h len=%0d fd=%0d",
                         run_idx, cur_an, cur_dp, cur_hex, cur_len, cur_fd,
                         e.an, e.dp, e.hex, e.len, e.fd);
            end
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (started && an === cur_an && dp === cur_dp) begin
                cur_len++;
                if (frame_done) cur_fd++;
            end else begin
                if (started) emit_run();
                started = 1'b1;
                cur_an  = an;
                cur_dp  = dp;
                cur_hex = digit_hex;
                cur_len = 1;
                cur_fd  = frame_done ? 1 : 0;
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Producer: hold the beat until it is taken; returns the accepting edge or -1.
    task automatic send(input logic [15:0] v, output int acc_cyc);
        bit acc;
        int n;
        n = 0;
        lif.load_valid = 1'b1;
        lif.load_data  = v;
        do begin
            acc = lif.load_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        acc_cyc = acc ? cyc : -1;
    endtask

    initial begin
        int a;
        lif.load_valid = 1'b0;
        lif.load_data  = 16'h0000;
        push_run(4'b1111, 1'b1, 4'h0, 0, 0);
        #1 reset_n = 1'b0;

        wait_until(2);
        check("reset_an", an, 4'b1111);
        check("reset_hex", digit_hex, 4'h0);
        check("reset_dp", dp, 1'b1);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_ready", lif.load_ready, 1'b1);

        wait_until(4);
        reset_n = 1'b1;

        // Load while dark: commits straight away because enable is low.
        wait_until(10);
        send(16'h1234, a);
        check("accept_1234", a, 11);
        lif.load_valid = 1'b0;
        check("ready_pending", lif.load_ready, 1'b0);
        wait_until(12);
        check("ready_after_off_commit", lif.load_ready, 1'b1);
        check("dark_while_disabled", an, 4'b1111);

        push_frame(16'h1234, 4'b0000, 4'b0000, 0);
        push_frame(16'h1234, 4'b0000, 4'b0000, 1);
        push_frame(16'h1234, 4'b0000, 4'b0000, 1);
        push_frame(16'h1234, 4'b0000, 4'b0000, 1);
        wait_until(15);
        enable = 1'b1;

        // Mid-frame load, then a held beat while pending, then a second beat.
        push_frame(16'hABCD, 4'b0000, 4'b0000, 1);
        push_frame(16'h5555, 4'b0000, 4'b0000, 1);
        push_frame(16'h6666, 4'b0000, 4'b0000, 1);
        wait_until(95);
        send(16'hABCD, a);
        check("accept_abcd", a, 96);
        send(16'h5555, a);
        check("accept_5555", a, 113);
        send(16'h6666, a);
        check("accept_6666", a, 137);
        lif.load_valid = 1'b0;

        // Digit 3 blanked, decimal point on digit 1.
        push_frame(16'h6666, 4'b1000, 4'b0010, 1);
        push_frame(16'h6666, 4'b1000, 4'b0010, 1);
        wait_until(182);
        blank_mask = 4'b1000;
        dp_mask    = 4'b0010;
        wait_until(230);
        blank_mask = 4'b0000;
        dp_mask    = 4'b0000;

        // Enable dropped two cycles into the digit-2 slot with 7777 pending.
        push_run(4'b1110, 1'b1, 4'h6, 4, 1);
        push_run(4'b1111, 1'b1, 4'h0, 2, 0);
        push_run(4'b1101, 1'b1, 4'h6, 4, 0);
        push_run(4'b1111, 1'b1, 4'h0, 2, 0);
        push_run(4'b1011, 1'b1, 4'h6, 2, 0);
        push_run(4'b1111, 1'b1, 4'h0, 4, 0);
        push_frame(16'h7777, 4'b0000, 4'b0000, 0);
        push_run(4'b1110, 1'b1, 4'h7, 4, 1);
        push_run(4'b1111, 1'b1, 4'h0, 0, 0);
        push_frame(16'h0000, 4'b0000, 4'b0000, 0);
        wait_until(233);
        send(16'h7777, a);
        check("accept_7777", a, 234);
        lif.load_valid = 1'b0;
        wait_until(245);
        enable = 1'b0;
        wait_until(246);
        check("disable_an", an, 4'b1111);
        check("disable_commit_ready", lif.load_ready, 1'b1);
        wait_until(249);
        enable = 1'b1;

        // Reset mid-blank with 8888 pending: the load must vanish.
        wait_until(275);
        send(16'h8888, a);
        check("accept_8888", a, 276);
        lif.load_valid = 1'b0;
        wait_until(278);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check("async_reset_an", an, 4'b1111);
        check("async_reset_hex", digit_hex, 4'h0);
        check("async_reset_dp", dp, 1'b1);
        check("async_reset_frame_done", frame_done, 1'b0);
        check("async_reset_ready", lif.load_ready, 1'b1);
        wait_until(282);
        reset_n = 1'b1;
        wait_until(290);
        check("post_reset_dark", an, 4'b1111);
        enable = 1'b1;

        wait_until(316);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
